// File: rtl/up_down_counter4.sv
// Free-running WIDTH-bit up/down counter with registered boundary flags,
// one-cycle wrap pulses and a registered copy of the last direction used.
module up_down_counter4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap_up,
  output logic             wrap_down,
  output logic             dir
);

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_d,     count_q;
  logic             at_max_d,    at_max_q;
  logic             at_min_d,    at_min_q;
  logic             wrap_up_d,   wrap_up_q;
  logic             wrap_down_d, wrap_down_q;
  logic             dir_d,       dir_q;

  // Next-state: flags come from the next count so they stay aligned with it.
  always_comb begin
    count_d     = count_q;
    wrap_up_d   = 1'b0;
    wrap_down_d = 1'b0;
    dir_d       = up;
    if (up) begin
      count_d   = count_q + ONE_VAL;
      wrap_up_d = (count_q == MAX_VAL);
    end else begin
      count_d     = count_q - ONE_VAL;
      wrap_down_d = (count_q == ZERO_VAL);
    end
    at_max_d = (count_d == MAX_VAL);
    at_min_d = (count_d == ZERO_VAL);
  end

  // State registers with asynchronous reset to the idle-at-zero state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= ZERO_VAL;
      at_max_q    <= 1'b0;
      at_min_q    <= 1'b1;
      wrap_up_q   <= 1'b0;
      wrap_down_q <= 1'b0;
      dir_q       <= 1'b1;
    end else begin
      count_q     <= count_d;
      at_max_q    <= at_max_d;
      at_min_q    <= at_min_d;
      wrap_up_q   <= wrap_up_d;
      wrap_down_q <= wrap_down_d;
      dir_q       <= dir_d;
    end
  end

  assign count     = count_q;
  assign at_max    = at_max_q;
  assign at_min    = at_min_q;
  assign wrap_up   = wrap_up_q;
  assign wrap_down = wrap_down_q;
  assign dir       = dir_q;

endmodule

// File: tb/tb_up_down_counter4.sv
// Randomized self-checking bench for up_down_counter4 against an
// integer-arithmetic reference model.
module tb_up_down_counter4;

  localparam int W    = 4;
  localparam int MODV = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         up;
  logic [W-1:0] count;
  logic         at_max;
  logic         at_min;
  logic         wrap_up;
  logic         wrap_down;
  logic         dir;

  int checks;
  int failures;

  // Reference model state
  int m_cnt;
  bit m_wu;
  bit m_wd;
  bit m_dir;

  up_down_counter4 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up       (up),
    .count    (count),
    .at_max   (at_max),
    .at_min   (at_min),
    .wrap_up  (wrap_up),
    .wrap_down(wrap_down),
    .dir      (dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_wu  = 1'b0;
    m_wd  = 1'b0;
    m_dir = 1'b1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},     int'(count),     m_cnt);
    chk({tag, ".at_max"},    int'(at_max),    int'(m_cnt == MODV - 1));
    chk({tag, ".at_min"},    int'(at_min),    int'(m_cnt == 0));
    chk({tag, ".wrap_up"},   int'(wrap_up),   int'(m_wu));
    chk({tag, ".wrap_down"}, int'(wrap_down), int'(m_wd));
    chk({tag, ".dir"},       int'(dir),       int'(m_dir));
  endtask

  // One counting edge: drive up now, model the edge, check just after it.
  task automatic step(input bit u, input string tag);
    int raw;
    up = u;
    @(posedge clk);
    #1;
    raw   = u ? m_cnt + 1 : m_cnt - 1;
    m_wu  = u && (raw == MODV);
    m_wd  = !u && (raw == -1);
    m_cnt = (raw + MODV) % MODV;
    m_dir = u;
    check_all(tag);
  endtask

  // Asynchronous reset pulse asserted between clock edges.
  task automatic async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".imm"});
    @(posedge clk);
    #1;
    check_all({tag, ".hold"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    up       = 1'b1;
    model_reset();

    #12;
    check_all("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) step(1'b1, "cnt_up");
    chk("cnt_up.final", int'(count), 10);
    for (int i = 0; i < 10; i++) step(1'b0, "cnt_dn");
    chk("cnt_dn.final", int'(count), 0);

    for (int i = 0; i < 13; i++) step(1'b1, "to13");
    step(1'b1, "wrap_u14");
    step(1'b1, "wrap_u15");
    chk("wrap_u.at_max15", int'(at_max), 1);
    step(1'b1, "wrap_u0");
    chk("wrap_u.pulse", int'(wrap_up), 1);
    step(1'b1, "wrap_u1");
    chk("wrap_u.cleared", int'(wrap_up), 0);

    step(1'b0, "wrap_d0");
    step(1'b0, "wrap_d15");
    chk("wrap_d.pulse", int'(wrap_down), 1);
    chk("wrap_d.value", int'(count), 15);
    step(1'b0, "wrap_d14");
    chk("wrap_d.cleared", int'(wrap_down), 0);

    for (int i = 0; i < 7; i++) step(1'b1, "to5");
    chk("to5.value", int'(count), 5);
    for (int i = 0; i < 4; i++) step(i[0] == 1'b0, "toggle");
    chk("toggle.final", int'(count), 5);

    async_reset("midrst");
    step(1'b1, "post_rst");
    chk("post_rst.value", int'(count), 1);

    // Random run with sticky direction so wraps occur, plus sporadic resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset("rnd_rst");
      end else begin
        if ($urandom_range(0, 9) == 0) up = ~up;
        step(up, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/up_down_counter4.md
# up_down_counter4

Free-running 4-bit (parameterisable) binary up/down counter that advances on every clock edge, in the direction selected by a single level input. It is a general-purpose sequencing and timing primitive inside a single clock domain. It provides the count value plus registered boundary and wrap status so downstream logic needs no extra comparators.

## Interface
Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is taken synchronously to clk by the user.
- up  input  1  direction select sampled each rising edge: 1 = increment, 0 = decrement.
- count  output  WIDTH  current counter value, registered.
- at_max  output  1  registered; high when count == 2^WIDTH-1.
- at_min  output  1  registered; high when count == 0.
- wrap_up  output  1  registered one-cycle pulse; high in the cycle after an increment from 2^WIDTH-1 to 0.
- wrap_down  output  1  registered one-cycle pulse; high in the cycle after a decrement from 0 to 2^WIDTH-1.
- dir  output  1  registered copy of the up value used for the most recent update.

## Operation
- No enable input: the counter updates on every rising clk edge while rst_n is high.
- up = 1: count <= count + 1, modulo 2^WIDTH.
- up = 0: count <= count - 1, modulo 2^WIDTH.
- Arithmetic is unsigned WIDTH-bit. There is no saturation; overflow and underflow wrap silently, apart from the wrap pulses.
- at_max and at_min are derived from the next-state value and registered with count, so they are always consistent with count in the same cycle.
- wrap_up is set on the edge where count goes 2^WIDTH-1 → 0 with up = 1, and is cleared on the next edge unless a wrap occurs again. wrap_down behaves the same way for 0 → 2^WIDTH-1 with up = 0.
- wrap_up and wrap_down are never high together.
- A direction change takes effect on the first edge at which the new up value is sampled. There is no turnaround cycle and no skipped value.
- Reset values, applied asynchronously while rst_n = 0:
  - count = 0, at_min = 1, at_max = 0.
  - wrap_up = 0, wrap_down = 0, dir = 1.
- Reset mid-operation: all outputs go to their reset values immediately, regardless of clk. Counting resumes from 0 at the first rising edge with rst_n high.

## Timing
- Latency is one cycle: the value of up sampled at edge N determines count after edge N.
- All outputs are registered. No combinational path exists from up to any output.
- First update after reset release occurs at the first rising edge at which rst_n is sampled high. From count 0 with up = 1, that edge yields count = 1.
- Holding up constant for 2^WIDTH edges returns count to its starting value and produces exactly one wrap pulse.
- up must meet setup/hold to clk. rst_n deassertion must meet recovery/removal to clk.

## Test plan
- Reset: hold rst_n = 0 for 12 ns (10 ns clock) with up = 1 → count = 0, at_min = 1, at_max = 0, no wrap pulses, dir = 1. Also assert rst_n asynchronously between edges → count = 0 within the same cycle.
- Count up: release reset, up = 1 for 10 edges → count steps 1, 2, …, 10; at_min drops after the first edge.
- Count down: from 10, up = 0 for 10 edges → count steps 9, …, 0; at_min = 1 at the final value; dir = 0 after the first down edge.
- Up wrap: up = 1 through 15 → 0 → count sequence 14, 15, 0, 1; at_max = 1 at 15; wrap_up high for exactly the cycle count = 0.
- Down wrap: up = 0 from 1 → count sequence 0, 15, 14; wrap_down high for exactly the cycle count = 15; at_max = 1 at 15.
- Direction toggle and mid-count reset: toggle up every edge starting at count 5 → count alternates 6, 5, 6, 5. Then pulse rst_n low mid-cycle → count = 0 immediately, and the next edge with up = 1 gives count = 1.
